// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand-forwarding selects and load-use stall,
// derived from a private shadow of the EX/MEM/WB destination/control fields.
module fwd_hazard_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  ex_valid_o,
    output logic [1:0]            ex_fwd_a_o,
    output logic [1:0]            ex_fwd_b_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam logic [1:0] SEL_RF    = 2'd0;
    localparam logic [1:0] SEL_EXMEM = 2'd1;
    localparam logic [1:0] SEL_MEMWB = 2'd2;

    logic                  ex_valid, ex_regwrite, ex_memread;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_valid, mem_regwrite, mem_memread;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  wb_valid, wb_regwrite, wb_memread;
    logic [REG_ADDR_W-1:0] wb_rd;

    logic [1:0]       fwd_a, fwd_b;
    logic [1:0]       fwd_a_nxt, fwd_b_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic             ex_prod, mem_prod, load_use, bubble;
    logic             unused_wb;

    // Hazard detection and next-cycle mux selects for the instruction entering EX.
    always_comb begin
        ex_prod   = ex_valid & ex_regwrite & (ex_rd != '0);
        mem_prod  = mem_valid & mem_regwrite & (mem_rd != '0);
        load_use  = id_valid_i & ~flush_i & ex_memread & ex_prod &
                    ((ex_rd == id_rs_i) | (ex_rd == id_rt_i));
        bubble    = load_use | flush_i | ~id_valid_i;
        fwd_a_nxt = SEL_RF;
        fwd_b_nxt = SEL_RF;
        if (!bubble) begin
            // Youngest producer wins: EX/MEM result ahead of MEM/WB result.
            if (ex_prod && !ex_memread && (ex_rd == id_rs_i)) begin
                fwd_a_nxt = SEL_EXMEM;
            end else if (mem_prod && (mem_rd == id_rs_i)) begin
                fwd_a_nxt = SEL_MEMWB;
            end
            if (ex_prod && !ex_memread && (ex_rd == id_rt_i)) begin
                fwd_b_nxt = SEL_EXMEM;
            end else if (mem_prod && (mem_rd == id_rt_i)) begin
                fwd_b_nxt = SEL_MEMWB;
            end
        end
    end

    // Shadow pipeline; stalls never freeze it, they only inject a bubble into EX.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid     <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_rd        <= '0;
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            mem_rd       <= '0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_memread   <= 1'b0;
            wb_rd        <= '0;
            fwd_a        <= SEL_RF;
            fwd_b        <= SEL_RF;
        end else begin
            wb_valid     <= mem_valid;
            wb_regwrite  <= mem_regwrite;
            wb_memread   <= mem_memread;
            wb_rd        <= mem_rd;
            mem_valid    <= ex_valid;
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
            mem_rd       <= ex_rd;
            if (load_use || flush_i) begin
                ex_valid    <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                ex_rd       <= '0;
            end else begin
                ex_valid    <= id_valid_i;
                ex_regwrite <= id_regwrite_i;
                ex_memread  <= id_memread_i;
                ex_rd       <= id_rd_i;
            end
            fwd_a <= fwd_a_nxt;
            fwd_b <= fwd_b_nxt;
        end
    end

    // Saturating count of cycles spent in load-use stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (load_use && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // WB exists only to give the MEM->WB shift a destination; nothing compares it.
    assign unused_wb = ^{wb_valid, wb_regwrite, wb_memread, wb_rd};

    assign stall_o     = load_use;
    assign ex_valid_o  = ex_valid;
    assign ex_fwd_a_o  = fwd_a;
    assign ex_fwd_b_o  = fwd_b;
    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: a pipeline-history model predicts each
// cycle's outputs; a negedge monitor pops and compares against two instances.
module tb_fwd_hazard_unit;

    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          id_valid_i = 1'b0;
    logic [AW-1:0] id_rs_i = '0, id_rt_i = '0, id_rd_i = '0;
    logic          id_regwrite_i = 1'b0, id_memread_i = 1'b0, flush_i = 1'b0;

    logic          stall_a, exv_a;
    logic [1:0]    fa_a, fb_a;
    logic [15:0]   cnt_a;
    logic          stall_b, exv_b;
    logic [1:0]    fa_b, fb_b;
    logic [1:0]    cnt_b;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i),
        .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
        .id_memread_i(id_memread_i), .flush_i(flush_i), .stall_o(stall_a),
        .ex_valid_o(exv_a), .ex_fwd_a_o(fa_a), .ex_fwd_b_o(fb_a), .stall_cnt_o(cnt_a)
    );

    fwd_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i),
        .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
        .id_memread_i(id_memread_i), .flush_i(flush_i), .stall_o(stall_b),
        .ex_valid_o(exv_b), .ex_fwd_a_o(fa_b), .ex_fwd_b_o(fb_b), .stall_cnt_o(cnt_b)
    );

    typedef struct {
        logic          v;
        logic [AW-1:0] rd;
        logic          rw;
        logic          mr;
        logic [1:0]    fa;
        logic [1:0]    fb;
    } stage_t;

    typedef struct {
        logic        stall;
        logic        exv;
        logic [1:0]  fa;
        logic [1:0]  fb;
        int unsigned cnt16;
        int unsigned cnt2;
        string       tag;
    } exp_t;

    exp_t   sb[$];
    stage_t pipe[$];      // pipe[0] = instruction in EX, pipe[1] = in MEM
    int unsigned n_stalls;
    int errors = 0;
    int checks = 0;

    function automatic stage_t empty_stage();
        stage_t s;
        s.v = 1'b0; s.rd = '0; s.rw = 1'b0; s.mr = 1'b0; s.fa = 2'd0; s.fb = 2'd0;
        return s;
    endfunction

    function automatic logic producer(stage_t s);
        return s.v && s.rw && (s.rd != '0);
    endfunction

    // Youngest older writer of src decides the source; a load in EX cannot supply data.
    function automatic logic [1:0] src_sel(logic [AW-1:0] src);
        for (int age = 0; age < 2; age++) begin
            if (producer(pipe[age]) && pipe[age].rd == src && !(age == 0 && pipe[age].mr))
                return 2'(age + 1);
        end
        return 2'd0;
    endfunction

    function automatic int unsigned sat(int unsigned n, int unsigned mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_reset();
        pipe.delete();
        pipe.push_back(empty_stage());
        pipe.push_back(empty_stage());
        n_stalls = 0;
    endtask

    task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%s] at %0t: got %0d expected %0d", name, tag, $time, act, exp);
        end
    endtask

    // One ID cycle: drive inputs, predict this cycle's outputs, advance the model.
    task automatic issue(input logic v, input int rs, input int rt, input int rd,
                         input logic rw, input logic mr, input logic fl, input string tag);
        exp_t   e;
        stage_t nx;
        logic   st;
        @(posedge clk); #1;
        rst_i = 1'b0;
        id_valid_i = v; id_rs_i = AW'(rs); id_rt_i = AW'(rt); id_rd_i = AW'(rd);
        id_regwrite_i = rw; id_memread_i = mr; flush_i = fl;
        st = v && !fl && pipe[0].mr && producer(pipe[0]) &&
             (pipe[0].rd == AW'(rs) || pipe[0].rd == AW'(rt));
        e.stall = st; e.exv = pipe[0].v; e.fa = pipe[0].fa; e.fb = pipe[0].fb;
        e.cnt16 = sat(n_stalls, 65535); e.cnt2 = sat(n_stalls, 3); e.tag = tag;
        sb.push_back(e);
        nx = empty_stage();
        if (v && !st && !fl) begin
            nx.v = 1'b1; nx.rd = AW'(rd); nx.rw = rw; nx.mr = mr;
            nx.fa = src_sel(AW'(rs)); nx.fb = src_sel(AW'(rt));
        end
        if (st) n_stalls++;
        pipe.push_front(nx);
        void'(pipe.pop_back());
    endtask

    // Assert reset partway through a cycle; all outputs must already read zero.
    task automatic hold_reset(input string tag);
        exp_t e;
        @(posedge clk); #1;
        id_valid_i = 1'b1; id_rs_i = 5'd2; id_rt_i = 5'd2; id_rd_i = 5'd4;
        id_regwrite_i = 1'b1; id_memread_i = 1'b0; flush_i = 1'b0;
        #1 rst_i = 1'b1;
        model_reset();
        e.stall = 1'b0; e.exv = 1'b0; e.fa = 2'd0; e.fb = 2'd0;
        e.cnt16 = 0; e.cnt2 = 0; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic idle();
        issue(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, "idle");
    endtask

    // Monitor: compares whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall", e.tag, 32'(stall_a), 32'(e.stall));
                chk("ex_valid", e.tag, 32'(exv_a), 32'(e.exv));
                chk("fwd_a", e.tag, 32'(fa_a), 32'(e.fa));
                chk("fwd_b", e.tag, 32'(fb_a), 32'(e.fb));
                chk("stall_cnt", e.tag, 32'(cnt_a), 32'(e.cnt16));
                chk("stall_w2", e.tag, 32'(stall_b), 32'(e.stall));
                chk("ex_valid_w2", e.tag, 32'(exv_b), 32'(e.exv));
                chk("fwd_a_w2", e.tag, 32'(fa_b), 32'(e.fa));
                chk("fwd_b_w2", e.tag, 32'(fb_b), 32'(e.fb));
                chk("stall_cnt_w2", e.tag, 32'(cnt_b), 32'(e.cnt2));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        hold_reset("reset");
        hold_reset("reset");

        issue(1, 0, 0, 3, 1, 0, 0, "exmem_a");
        issue(1, 3, 4, 9, 1, 0, 0, "exmem_a");
        idle();

        issue(1, 0, 0, 5, 1, 0, 0, "memwb_b");
        issue(1, 8, 9, 10, 1, 0, 0, "memwb_b");
        issue(1, 1, 5, 11, 1, 0, 0, "memwb_b");
        idle();

        issue(1, 0, 0, 7, 1, 0, 0, "youngest");
        issue(1, 0, 0, 7, 1, 0, 0, "youngest");
        issue(1, 7, 7, 12, 1, 0, 0, "youngest");
        idle();

        issue(1, 0, 0, 2, 1, 1, 0, "load_use");
        issue(1, 2, 6, 12, 1, 0, 0, "load_use");
        issue(1, 2, 6, 12, 1, 0, 0, "load_use");
        idle();
        idle();

        issue(1, 0, 0, 2, 1, 1, 0, "ld_flush");
        issue(1, 2, 6, 12, 1, 0, 1, "ld_flush");
        idle();
        idle();

        issue(1, 0, 0, 0, 1, 0, 0, "r0");
        issue(1, 0, 0, 13, 1, 0, 0, "r0");
        idle();

        for (int k = 0; k < 4; k++) begin
            issue(1, 0, 0, 2, 1, 1, 0, "saturate");
            issue(1, 6, 2, 14, 1, 0, 0, "saturate");
            issue(1, 6, 2, 14, 1, 0, 0, "saturate");
        end
        idle();

        issue(1, 0, 0, 2, 1, 1, 0, "mid_reset");
        issue(1, 0, 0, 6, 1, 0, 0, "mid_reset");
        hold_reset("mid_reset");
        idle();
        idle();

        for (int k = 0; k < 2000; k++) begin
            issue(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0, "random");
            if ($urandom_range(0, 199) == 0) hold_reset("rand_reset");
        end
        idle();

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", "end", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Generates the 2-bit select codes for the two EX-stage 3-to-1 operand muxes (A and B) of each core, and the load-use stall.
- Sits beside the ID/EX boundary.
- Keeps its own shadow pipeline of destination-register and control fields for the EX, MEM and WB stages.
- Select encoding: 0 = register-file operand, 1 = EX/MEM result, 2 = MEM/WB result. Code 3 is never driven.

Parameters:
REG_ADDR_W, 5, register-address width
CNT_W, 16, width of the stall performance counter

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  reset, asynchronous, active-high
id_valid_i  input  1  ID stage holds a real instruction
id_rs_i  input  REG_ADDR_W  source register A of the ID instruction
id_rt_i  input  REG_ADDR_W  source register B of the ID instruction
id_rd_i  input  REG_ADDR_W  destination register of the ID instruction
id_regwrite_i  input  1  ID instruction writes the register file
id_memread_i  input  1  ID instruction is a load
flush_i  input  1  kill the ID instruction (branch taken)
stall_o  output  1  hold PC and IF/ID, insert bubble into EX (combinational)
ex_valid_o  output  1  EX stage holds a real instruction (registered)
ex_fwd_a_o  output  2  select for the EX operand-A mux (registered)
ex_fwd_b_o  output  2  select for the EX operand-B mux (registered)
stall_cnt_o  output  CNT_W  saturating count of stall cycles

Behaviour:
- Shadow stages
  - EX, MEM and WB each hold {valid, rd, regwrite, memread}.
  - The WB stage is retained only so that the MEM-to-WB shift is well defined; its contents are never compared.
  - Every cycle: MEM -> WB, EX -> MEM, unconditionally. Stalls never freeze the EX, MEM or WB stages.
  - EX loads the ID fields with valid = id_valid_i.
  - EX instead loads a bubble (valid=0, regwrite=0, memread=0) when stall_o=1 or flush_i=1.
- Reset
  - While rst_i is high, every stage is cleared to valid=0, regwrite=0 and memread=0.
  - Outputs under reset: ex_valid_o=0, ex_fwd_a_o=0, ex_fwd_b_o=0, stall_cnt_o=0, stall_o=0.
  - Asserting reset mid-operation discards all in-flight state immediately.
- "Producer" qualifier: a stage is a producer when valid=1, regwrite=1 and rd != 0. Register 0 is never forwarded.
- Load-use stall (combinational)
  - stall_o = id_valid_i & !flush_i & EX.memread & EX is a producer & (EX.rd == id_rs_i | EX.rd == id_rt_i).
  - A flush therefore suppresses the stall.
- Select computation
  - Computed for the instruction entering EX; registered, so the codes are valid for the whole cycle that instruction sits in EX.
  - For source s (rs -> A, rt -> B):
    - if the current EX stage is a producer and EX.rd == s (and is not a load): next select = 1;
    - else if the current MEM stage is a producer and MEM.rd == s: next select = 2;
    - else: next select = 0.
  - Priority: 1 beats 2 (youngest producer wins).
  - When a bubble enters EX, both selects load 0.
- Load-use resolution: after the single bubble the load is in MEM/WB when the consumer reaches EX, so the consumer receives select 2.
- No write-back forwarding: the register file is write-before-read, so a producer already in WB needs no forwarding.
- Stall counter: increments by 1 on each rising edge where stall_o=1; saturates at all-ones and does not wrap.
- Latency
  - ex_valid_o, ex_fwd_a_o and ex_fwd_b_o change 1 cycle after the ID inputs are sampled.
  - stall_o responds within the same cycle.

Test Plan:
- Reset check: assert rst_i asynchronously mid-cycle with EX/MEM loaded -> all outputs 0 immediately; stall_cnt_o=0.
- EX/MEM forwarding on A: issue add r3 (rd=3, regwrite=1), then sub rs=3, rt=4 -> during sub's EX cycle ex_fwd_a_o=1, ex_fwd_b_o=0.
- MEM/WB forwarding on B: issue add r5, then an unrelated instruction, then rs=1, rt=5 -> third instruction's EX cycle ex_fwd_b_o=2.
- Youngest producer wins: two back-to-back writes to r7, then a reader of rs=rt=7 -> ex_fwd_a_o=1, ex_fwd_b_o=1.
- Load-use, no flush: lw r2, then rs=2 -> stall_o=1 for exactly one cycle; next EX cycle ex_valid_o=0; the cycle after, ex_fwd_a_o=2; stall_cnt_o=1.
- Load-use with flush_i=1 in the stall cycle -> stall_o=0, bubble enters EX, stall_cnt_o unchanged.
- r0 writer followed by rs=0 reader -> select 0.
- Counter saturation with CNT_W=2: four consecutive stall cycles -> stall_cnt_o holds 3.
